// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared op codes and FSM state encodings for the iterative
//               shifter (shift_unit_iter) and its single-step datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

    // Shift mode encodings presented on sl_op
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : Combinational single-step shifter. Shifts the operand by
//               k = 0..STEP positions according to op, applying the
//               mode-specific fill. Rotate-right hardware exists only when
//               SHIFT_UNIT_ROTATE_EN is defined; otherwise op 11 acts as SRL.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int KW   = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] out
);

`ifdef SHIFT_UNIT_ROTATE_EN
    localparam int AW = $clog2(WIDTH) + 1;
    // Left-shift distance that brings the bits dropped off the LSB to the MSB.
    // k=0 gives a distance of WIDTH, which yields zero and leaves 'in' intact.
    logic [AW-1:0] w_rot_dist;
    assign w_rot_dist = AW'(WIDTH) - AW'(k);
`endif

    // Mode-dependent shift of the working value by k positions
    always_comb begin
        out = in;
        case (op)
            OP_SLL:  out = in << k;
            OP_SRL:  out = in >> k;
            OP_SRA:  out = WIDTH'($signed(in) >>> k);
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  out = (in >> k) | (in << w_rot_dist);
`else
            OP_ROR:  out = in >> k;
`endif
            default: out = in;
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit_iter
// Description : Iterative shifter for the MIPS datapath. Accepts an operand,
//               mode and amount under a start/busy/done handshake and shifts
//               STEP positions per clock until the amount is consumed.
//               Optional macro: SHIFT_UNIT_ROTATE_EN enables rotate-right on
//               op 11 (otherwise op 11 is a logical right shift).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_unit_iter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 sl_op,
    input  logic [$clog2(WIDTH)-1:0]   sl_shamt,
    input  logic [WIDTH-1:0]           sl_input,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           sl_output
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int KW      = $clog2(STEP) + 1;
    // Wide enough to hold both STEP and any remaining count without overflow
    localparam int CW      = SHAMT_W + 1;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_work;
    logic [SHAMT_W-1:0]   r_rem;
    logic [1:0]           r_op;
    logic [CW-1:0]        w_k_wide;
    logic [KW-1:0]        w_k;
    logic [SHAMT_W-1:0]   w_rem_after;
    logic [WIDTH-1:0]     w_step_out;

    // This cycle's step size: the smaller of STEP and what is left to shift
    always_comb begin
        w_k_wide    = (CW'(r_rem) >= CW'(STEP)) ? CW'(STEP) : CW'(r_rem);
        w_k         = w_k_wide[KW-1:0];
        w_rem_after = r_rem - SHAMT_W'(w_k_wide);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .in  (r_work),
        .op  (r_op),
        .k   (w_k),
        .out (w_step_out)
    );

    // State register plus operand/counter datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_work <= sl_input;
                        r_op   <= sl_op;
                        r_rem  <= sl_shamt;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_step_out;
                    r_rem  <= w_rem_after;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (sl_shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                w_next = (w_rem_after == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign sl_output = r_work;

endmodule : shift_unit_iter
`default_nettype wire

// File: tb/tb_shift_unit_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_unit_iter
// Description : Directed self-checking bench for shift_unit_iter. One
//               instance with STEP=1 and one with STEP=4, both WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start,  start4;
    logic [1:0]  sl_op,  sl_op4;
    logic [4:0]  sl_shamt, sl_shamt4;
    logic [31:0] sl_input, sl_input4;
    logic        busy, done, busy4, done4;
    logic [31:0] sl_output, sl_output4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .sl_op(sl_op),
        .sl_shamt(sl_shamt), .sl_input(sl_input),
        .busy(busy), .done(done), .sl_output(sl_output)
    );

    shift_unit_iter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sl_op(sl_op4),
        .sl_shamt(sl_shamt4), .sl_input(sl_input4),
        .busy(busy4), .done(done4), .sl_output(sl_output4)
    );

    // Present a job to the STEP=1 instance for exactly one accepting edge;
    // returns 1ns after that edge.
    task automatic launch(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d);
        @(posedge clk); #1;
        start = 1'b1; sl_op = op; sl_shamt = sh; sl_input = d;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen on the STEP=1 instance (bounded)
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sl_output !== 32'h0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, sl_output);
        end
        tests++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sl_output4 !== 32'h0) begin
            fails++;
            $display("FAIL reset_step4: busy=%b done=%b out=%h, required 0 0 00000000", busy4, done4, sl_output4);
        end
        rst = 1'b0;
    endtask

    task automatic test_sll();
        logic [2:0] b, dn;
        launch(2'b00, 5'd2, 32'h0000_0001);
        b[0] = busy; dn[0] = done;
        @(posedge clk); #1; b[1] = busy; dn[1] = done;
        @(posedge clk); #1; b[2] = busy; dn[2] = done;
        tests++;
        if (b !== 3'b111 || dn !== 3'b100) begin
            fails++;
            $display("FAIL sll_handshake: busy=%b done=%b, required 111 100", b, dn);
        end
        tests++;
        if (sl_output !== 32'h0000_0004) begin
            fails++;
            $display("FAIL sll_result: got %h, required 00000004", sl_output);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sl_output !== 32'h0000_0004) begin
            fails++;
            $display("FAIL sll_idle_hold: busy=%b done=%b out=%h, required 0 0 00000004", busy, done, sl_output);
        end
    endtask

    task automatic test_sra();
        int cyc;
        launch(2'b10, 5'd31, 32'h8000_0000);
        wait_done(cyc);
        tests++;
        if (cyc != 31 || sl_output !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sra31: cycles=%0d out=%h, required 31 FFFFFFFF", cyc, sl_output);
        end
        launch(2'b10, 5'd4, 32'h7000_0010);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || sl_output !== 32'h0700_0001) begin
            fails++;
            $display("FAIL sra_pos: cycles=%0d out=%h, required 4 07000001", cyc, sl_output);
        end
    endtask

    task automatic test_shamt0();
        int cyc;
        for (int op = 0; op < 4; op++) begin
            launch(op[1:0], 5'd0, 32'hDEAD_BEEF);
            wait_done(cyc);
            tests++;
            if (cyc != 0 || sl_output !== 32'hDEAD_BEEF) begin
                fails++;
                $display("FAIL shamt0_op%0d: cycles=%0d out=%h, required 0 DEADBEEF", op, cyc, sl_output);
            end
        end
    endtask

    task automatic test_step4();
        logic [31:0] vin [2]   = '{32'hF000_0000, 32'h0000_0001};
        logic [1:0]  vop [2]   = '{2'b01, 2'b00};
        logic [4:0]  vsh [2]   = '{5'd7, 5'd31};
        logic [31:0] vexp [2]  = '{32'h01E0_0000, 32'h8000_0000};
        int          vcyc [2]  = '{2, 8};
        int cyc;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start4 = 1'b1; sl_op4 = vop[i]; sl_shamt4 = vsh[i]; sl_input4 = vin[i];
            @(posedge clk); #1;
            start4 = 1'b0;
            cyc = 0;
            while (done4 !== 1'b1 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            tests++;
            if (cyc != vcyc[i] || sl_output4 !== vexp[i]) begin
                fails++;
                $display("FAIL step4_vec%0d: cycles=%0d out=%h, required %0d %h", i, cyc, sl_output4, vcyc[i], vexp[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        launch(2'b00, 5'd4, 32'h0000_0001);
        // Competing requests while the first job is in flight
        start = 1'b1; sl_op = 2'b01; sl_shamt = 5'd3; sl_input = 32'hFFFF_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc != 4 || sl_output !== 32'h0000_0010) begin
            fails++;
            $display("FAIL busy_ignore: cycles=%0d out=%h, required 4 00000010", cyc, sl_output);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || sl_output !== 32'h0000_0010) begin
            fails++;
            $display("FAIL busy_ignore_idle: busy=%b out=%h, required 0 00000010", busy, sl_output);
        end
        launch(2'b01, 5'd4, 32'h0000_1000);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || sl_output !== 32'h0000_0100) begin
            fails++;
            $display("FAIL back_to_back: cycles=%0d out=%h, required 4 00000100", cyc, sl_output);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        launch(2'b00, 5'd10, 32'h0000_0001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sl_output !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b out=%h, required 0 0 00000000", busy, done, sl_output);
        end
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_mid_no_done: active cycles=%0d, required 0", seen);
        end
    endtask

    task automatic test_ror();
        int cyc;
        logic [31:0] exp1, exp2;
`ifdef SHIFT_UNIT_ROTATE_EN
        exp1 = 32'h8000_0000;
        exp2 = 32'h1000_000F;
`else
        exp1 = 32'h0000_0000;
        exp2 = 32'h0000_000F;
`endif
        launch(2'b11, 5'd1, 32'h0000_0001);
        wait_done(cyc);
        tests++;
        if (cyc != 1 || sl_output !== exp1) begin
            fails++;
            $display("FAIL ror1: cycles=%0d out=%h, required 1 %h", cyc, sl_output, exp1);
        end
        launch(2'b11, 5'd4, 32'h0000_00F1);
        wait_done(cyc);
        tests++;
        if (cyc != 4 || sl_output !== exp2) begin
            fails++;
            $display("FAIL ror4: cycles=%0d out=%h, required 4 %h", cyc, sl_output, exp2);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; sl_op = 2'b00; sl_shamt = 5'd0; sl_input = 32'h0;
        start4 = 1'b0; sl_op4 = 2'b00; sl_shamt4 = 5'd0; sl_input4 = 32'h0;
        test_reset();
        test_sll();
        test_sra();
        test_shamt0();
        test_step4();
        test_busy_ignore();
        test_reset_mid();
        test_ror();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_shift_unit_iter
`default_nettype wire
